// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter: FSM state encoding,
// default data width and frame-length helper.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam int UART_DATA_W = 8;

  // Baud ticks from grant edge to the edge that ends the last stop bit.
  function automatic int frame_len(input int data_w, input int stop_bits);
    return 1 + data_w + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side bus of the arbitrated UART transmitter: byte requests in,
// per-requester acknowledge, grant index, busy flag and the serial line out.
interface uart_tx_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        ack;
  logic [1:0]              gnt_id;
  logic                    busy;
  logic                    tx;

  modport master (output req, data, input ack, gnt_id, busy, tx);
  modport slave  (input req, data, output ack, gnt_id, busy, tx);
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past the pointer and
// the first active request wins.
module uart_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [1:0]       gnt_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   req_rot;
  logic [2:0]         start;
  int                 sel;

  // Doubling the vector lets a plain shift rotate the search origin to ptr+1.
  assign req2    = {req, req};
  assign start   = {1'b0, ptr} + 3'd1;
  assign req_rot = N_REQ'(req2 >> start);
  assign any     = |req;

  always_comb begin
    sel = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) sel = j;
    end
    gnt_idx = 2'((int'(ptr) + 1 + sel) % N_REQ);
    gnt_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = any && (gnt_idx == 2'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmitter shared by N_REQ byte producers, round-robin arbitrated,
// framing start + DATA_W bits (LSB first) + STOP_BITS stop bits on baud_tick.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = UART_DATA_W,
  parameter int STOP_BITS = 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          baud_tick,
  uart_tx_arb_if.slave  bus
);

  localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                tx_q, tx_d;
  logic [N_REQ-1:0]    ack_q, ack_d;

  logic [N_REQ-1:0]    win_oh;
  logic [1:0]          win_idx;
  logic                win_any;
  logic                last_stop, grant_pt, grant_go;

  uart_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == STOP_LAST);
  assign grant_pt  = baud_tick && ((state_q == ST_IDLE) || last_stop);
  assign grant_go  = grant_pt && win_any;

  // state | meaning
  // IDLE  | line high, waiting for a request on a tick
  // START | start bit on the line, byte latched
  // DATA  | data bit bit_cnt on the line
  // STOP  | stop bit stop_cnt on the line; last one is a grant point
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE:  if (win_any) state_d = ST_START;
        ST_START: state_d = ST_DATA;
        ST_DATA:  if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        ST_STOP:  if (last_stop) state_d = win_any ? ST_START : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ack_d      = '0;
    if (grant_go) begin
      ptr_d = win_idx;
      gnt_d = win_idx;
      ack_d = win_oh;
      tx_d  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (win_oh[i]) shift_d = DATA_W'(bus.data >> (i * DATA_W));
      end
    end else if (baud_tick) begin
      case (state_q)
        ST_START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_STOP: if (!last_stop) stop_cnt_d = stop_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Reset drives tx high immediately so an aborted frame never leaves the line low.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ptr_q      <= 2'(N_REQ - 1);
      gnt_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ack_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a frame-level model (bit list per granted byte) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arb;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int FLEN = 1 + DW + 1;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic tick2 = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  uart_tx_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  uart_tx_arb_if #(.N_REQ(2), .DATA_W(DW)) bus2 ();

  uart_tx_arb #(.N_REQ(N), .DATA_W(DW), .STOP_BITS(1)) dut (
    .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .bus(bus));

  uart_tx_arb #(.N_REQ(2), .DATA_W(DW), .STOP_BITS(2)) dut2 (
    .clk_in(clk_in), .rst(rst), .baud_tick(tick2), .bus(bus2));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: a granted byte becomes a list of line levels.
  int       m_ptr = N - 1;
  bit       m_in = 1'b0;
  bit       m_bits[$];
  int       m_pos = 0;
  bit [N-1:0] m_ack = '0;
  int       m_gnt = 0;
  bit       m_last_tick = 1'b0;

  always @(posedge clk_in or posedge rst) begin
    bit gp;
    int w;
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    logic [DW-1:0]   byt;
    if (rst) begin
      m_ptr = N - 1; m_in = 1'b0; m_ack = '0; m_gnt = 0; m_last_tick = 1'b0; m_pos = 0;
    end else begin
      r = bus.req;
      d = bus.data;
      m_ack = '0;
      m_last_tick = baud_tick;
      if (baud_tick) begin
        gp = !m_in;
        if (m_in) begin
          m_pos++;
          if (m_pos == FLEN) begin gp = 1'b1; m_in = 1'b0; end
        end
        if (gp) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && (((r >> ((m_ptr + k) % N)) & 1) != 0)) w = (m_ptr + k) % N;
          if (w >= 0) begin
            byt = DW'(d >> (w * DW));
            m_bits.delete();
            m_bits.push_back(1'b0);
            for (int b = 0; b < DW; b++) begin
              m_bits.push_back(byt[0]);
              byt = byt >> 1;
            end
            m_bits.push_back(1'b1);
            m_ptr = w; m_gnt = w; m_ack = N'(1 << w);
            m_pos = 0; m_in = 1'b1;
          end
        end
      end
    end
  end

  int tx_log[$];
  int ack_log[$];

  always @(negedge clk_in) begin
    if (!rst) begin
      chk("tx", int'(bus.tx), m_in ? int'(m_bits[m_pos]) : 1);
      chk("busy", int'(bus.busy), int'(m_in));
      chk("ack", int'(bus.ack), int'(m_ack));
      chk("gnt_id", int'(bus.gnt_id), m_gnt);
      if (m_last_tick) tx_log.push_back(int'(bus.tx));
      for (int i = 0; i < N; i++)
        if (((bus.ack >> i) & 1) != 0) ack_log.push_back(i);
    end
  end

  int tick_per = 0;
  int tcnt = 0;
  bit auto_req = 1'b0;
  bit drop_on_ack = 1'b0;

  function automatic logic [N*DW-1:0] put_byte(input logic [N*DW-1:0] v, input int i,
                                               input logic [DW-1:0] b);
    logic [N*DW-1:0] m;
    m = (N*DW)'({DW{1'b1}}) << (i * DW);
    return (v & ~m) | (((N*DW)'(b)) << (i * DW));
  endfunction

  task automatic cyc();
    bit acked;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < N; i++) begin
      acked = ((bus.ack >> i) & 1) != 0;
      if (drop_on_ack && acked) bus.req = bus.req & ~N'(1 << i);
      if (auto_req) begin
        if (((bus.req >> i) & 1) == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            bus.data = put_byte(bus.data, i, 8'($urandom_range(0, 255)));
            bus.req  = bus.req | N'(1 << i);
          end
        end else if (!acked && $urandom_range(0, 63) == 0) begin
          bus.req = bus.req & ~N'(1 << i);
        end
      end
    end
    if (tick_per == 0) baud_tick = 1'b0;
    else begin
      baud_tick = (tcnt % tick_per) == 0;
      tcnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b1; bus.req = '0; baud_tick = 1'b0; tick_per = 0; tcnt = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin cyc(); c++; end
    chk({name, "_timeout"}, ack_log.size() >= n ? 1 : 0, 1);
  endtask

  initial begin
    int a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int rr[4]  = '{0, 1, 0, 1};
    int s2[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int c, ack_cnt, busy_cnt;
    int seq[$];

    bus.req = '0; bus.data = '0; bus2.req = '0; bus2.data = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst = 1'b0;
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_gnt", int'(bus.gnt_id), 0);

    // quiet line with slow ticks
    tick_per = 435; tcnt = 1;
    repeat (1000) cyc();
    chk("quiet_acks", ack_log.size(), 0);
    chk("quiet_tx", int'(bus.tx), 1);

    // single frame of 8'hA5
    do_reset();
    tick_per = 4; tcnt = 1; drop_on_ack = 1'b1;
    tx_log.delete(); ack_log.delete();
    bus.data = put_byte('0, 0, 8'hA5);
    bus.req  = 3'b001;
    wait_acks(1, 40, "a5_ack");
    repeat (60) cyc();
    chk("a5_ack_cnt", ack_log.size(), 1);
    chk("a5_ack_id", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("a5_bit%0d", k), tx_log.size() > k ? tx_log[k] : -1, a5[k]);
    chk("a5_idle_busy", int'(bus.busy), 0);

    // two requesters held high: strict alternation, back-to-back frames
    do_reset();
    tick_per = 2; tcnt = 0; drop_on_ack = 1'b0;
    ack_log.delete();
    bus.data = put_byte(put_byte('0, 0, 8'h55), 1, 8'h0F);
    bus.req  = 3'b011;
    wait_acks(4, 200, "rr_acks");
    bus.req = '0;
    repeat (60) cyc();
    chk("rr_ack_cnt", ack_log.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), ack_log.size() > k ? ack_log[k] : -1, rr[k]);

    // reset in the middle of data bit 4
    do_reset();
    tick_per = 3; tcnt = 0; drop_on_ack = 1'b1;
    tx_log.delete(); ack_log.delete();
    bus.data = put_byte('0, 0, 8'h00);
    bus.req  = 3'b001;
    c = 0;
    while (tx_log.size() < 6 && c < 100) begin cyc(); c++; end
    chk("abort_reach_bit4", tx_log.size() >= 6 ? 1 : 0, 1);
    chk("abort_pre_tx", int'(bus.tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx_async", int'(bus.tx), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ack", int'(bus.ack), 0);
    @(posedge clk_in);
    #1;
    rst = 1'b0; tcnt = 0;
    ack_log.delete();
    bus.data = put_byte(put_byte('0, 0, 8'h5A), 1, 8'hC3);
    bus.req  = 3'b011;
    wait_acks(2, 200, "post_abort_acks");
    repeat (40) cyc();
    chk("post_abort_first", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    chk("post_abort_second", ack_log.size() > 1 ? ack_log[1] : -1, 1);

    // request withdrawn between ticks
    do_reset();
    tick_per = 8; tcnt = 0; drop_on_ack = 1'b0;
    c = 0;
    do begin cyc(); c++; end while (!m_last_tick && c < 20);
    chk("drop_tick_found", int'(m_last_tick), 1);
    ack_log.delete();
    bus.data = put_byte('0, 1, 8'h77);
    bus.req  = 3'b010;
    repeat (3) cyc();
    bus.req = '0;
    repeat (40) cyc();
    chk("drop_no_ack", ack_log.size(), 0);
    chk("drop_busy", int'(bus.busy), 0);

    // two stop bits, tick tied high
    do_reset();
    tick2 = 1'b1;
    bus2.data = {8'h00, 8'h3C};
    bus2.req  = 2'b01;
    ack_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (bus2.ack != 0) ack_cnt++;
      if (bus2.busy) begin busy_cnt++; seq.push_back(int'(bus2.tx)); end
      if (bus2.ack[0]) bus2.req = '0;
    end
    tick2 = 1'b0;
    chk("sb2_frame_len", busy_cnt, 11);
    chk("sb2_ack_width", ack_cnt, 1);
    for (int k = 0; k < 11; k++)
      chk($sformatf("sb2_bit%0d", k), seq.size() > k ? seq[k] : -1, s2[k]);
    chk("sb2_idle_tx", int'(bus2.tx), 1);

    // randomized traffic with varying tick rates and one async reset
    do_reset();
    auto_req = 1'b1; drop_on_ack = 1'b1;
    for (int s = 0; s < 20; s++) begin
      tick_per = $urandom_range(1, 6);
      repeat (300) cyc();
      if (s == 10) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    auto_req = 1'b0;
    bus.req = '0;
    repeat (100) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
